// File: rtl/alu_cmp_if.sv
// Handshake bundle for alu_cmp_pipe: operand request channel (in_*) and
// result channel (out_*). The slave modport is the pipeline's view.
interface alu_cmp_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           opc;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   c;
  logic [2:0]           c_opc;

  modport master (
    output in_valid, opc, a, b, out_ready,
    input  in_ready, out_valid, c, c_opc
  );

  modport slave (
    input  in_valid, opc, a, b, out_ready,
    output in_ready, out_valid, c, c_opc
  );
endinterface

// File: rtl/alu_cmp_pipe.sv
// Two-stage pipelined ALU / comparator with valid/ready flow control.
// S1 captures opcode and operands, S2 computes and holds the result until the
// consumer takes it. A counter tracks completed hand-offs.
module alu_cmp_pipe #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmp_if.slave         bus,
  output logic [CNT_W-1:0] op_count
);

  localparam int CW = 2 * WIDTH;

  // Stage 1 holding registers
  logic             s1_valid_reg;
  logic [2:0]       s1_opc_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;

  // Stage 2 / output registers
  logic             out_valid_reg;
  logic [CW-1:0]    c_reg;
  logic [2:0]       c_opc_reg;
  logic [CNT_W-1:0] op_count_reg;

  // Flow control
  logic s2_load;
  logic s1_load;

  // Datapath
  logic [CW-1:0] a_ext;
  logic [CW-1:0] b_ext;
  logic [CW-1:0] a_cmp;
  logic [CW-1:0] b_cmp;
  logic [CW-1:0] sign_flip;
  logic [CW-1:0] result_next;

  // S2 may take new data when empty or when its current result leaves now;
  // S1 may take new data when empty or when it can move into S2.
  assign s2_load = !out_valid_reg || bus.out_ready;
  assign s1_load = !s1_valid_reg || s2_load;

  // Held low while reset is asserted so nothing is accepted in that cycle.
  assign bus.in_ready = s1_load && !rst;

  // Widen operands to the result width; the upper bits replicate the sign
  // only in signed mode.
  assign a_ext[WIDTH-1:0] = s1_a_reg;
  assign b_ext[WIDTH-1:0] = s1_b_reg;
  generate
    for (genvar gi = WIDTH; gi < CW; gi++) begin : g_ext
      assign a_ext[gi] = (SIGNED != 0) && s1_a_reg[WIDTH-1];
      assign b_ext[gi] = (SIGNED != 0) && s1_b_reg[WIDTH-1];
    end
  endgenerate

  // Flipping the MSB of the extended values maps two's complement order onto
  // unsigned order, so one set of unsigned comparators serves both modes.
  assign sign_flip = {(SIGNED != 0), {(CW-1){1'b0}}};
  assign a_cmp     = a_ext ^ sign_flip;
  assign b_cmp     = b_ext ^ sign_flip;

  // Result selection for the operation currently held in S1.
  always_comb begin
    result_next = '0;
    case (s1_opc_reg)
      3'd0:    result_next = a_ext + b_ext;
      3'd1:    result_next = a_ext - b_ext;
      3'd2:    result_next = a_ext * b_ext;
      3'd3:    result_next = {{(CW-1){1'b0}}, (a_cmp >  b_cmp)};
      3'd4:    result_next = {{(CW-1){1'b0}}, (a_cmp <  b_cmp)};
      3'd5:    result_next = {{(CW-1){1'b0}}, (a_cmp == b_cmp)};
      3'd6:    result_next = {{(CW-1){1'b0}}, (a_cmp >= b_cmp)};
      default: result_next = {{(CW-1){1'b0}}, (a_cmp <= b_cmp)};
    endcase
  end

  // Stage 1: capture an accepted operation, or go empty when it moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_opc_reg   <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_opc_reg <= bus.opc;
        s1_a_reg   <= bus.a;
        s1_b_reg   <= bus.b;
      end
    end
  end

  // Stage 2: register the computed result; hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      c_reg         <= '0;
      c_opc_reg     <= '0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        c_reg     <= result_next;
        c_opc_reg <= s1_opc_reg;
      end
    end
  end

  // Completed-operation counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (out_valid_reg && bus.out_ready) begin
      op_count_reg <= op_count_reg + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.c         = c_reg;
  assign bus.c_opc     = c_opc_reg;
  assign op_count      = op_count_reg;

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Bench for alu_cmp_pipe: three instances (unsigned, signed, 2-bit counter).
// Table vectors, hand-built corner sequences and a randomized run checked
// against an integer-arithmetic reference model with a result queue.
module tb_alu_cmp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Per-instance stimulus (procedural only)
  logic       iv   [3];
  logic [2:0] io   [3];
  logic [3:0] ia   [3];
  logic [3:0] ib   [3];
  logic       ordy [3];

  // Per-instance observed outputs (continuous only)
  logic       ir   [3];
  logic       ov   [3];
  logic [7:0] oc   [3];
  logic [2:0] oo   [3];
  logic [7:0] cnt  [3];

  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  alu_cmp_if #(.WIDTH(4)) if0 ();
  alu_cmp_if #(.WIDTH(4)) if1 ();
  alu_cmp_if #(.WIDTH(4)) if2 ();

  alu_cmp_pipe #(.WIDTH(4), .SIGNED(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0), .op_count(cnt0));
  alu_cmp_pipe #(.WIDTH(4), .SIGNED(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1), .op_count(cnt1));
  alu_cmp_pipe #(.WIDTH(4), .SIGNED(0), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(if2), .op_count(cnt2));

  assign if0.in_valid = iv[0];  assign if0.opc = io[0];  assign if0.a = ia[0];
  assign if0.b = ib[0];         assign if0.out_ready = ordy[0];
  assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;
  assign oc[0] = if0.c;         assign oo[0] = if0.c_opc;  assign cnt[0] = cnt0;

  assign if1.in_valid = iv[1];  assign if1.opc = io[1];  assign if1.a = ia[1];
  assign if1.b = ib[1];         assign if1.out_ready = ordy[1];
  assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;
  assign oc[1] = if1.c;         assign oo[1] = if1.c_opc;  assign cnt[1] = cnt1;

  assign if2.in_valid = iv[2];  assign if2.opc = io[2];  assign if2.a = ia[2];
  assign if2.b = ib[2];         assign if2.out_ready = ordy[2];
  assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;
  assign oc[2] = if2.c;         assign oo[2] = if2.c_opc;  assign cnt[2] = {6'b0, cnt2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: operands as plain integers, result reduced mod 256.
  function automatic logic [7:0] model(input bit sgn, input logic [2:0] o,
                                       input logic [3:0] x, input logic [3:0] y);
    int av;
    int bv;
    int r;
    av = int'(x);
    bv = int'(y);
    if (sgn && x[3]) av = av - 16;
    if (sgn && y[3]) bv = bv - 16;
    case (o)
      3'd0:    r = av + bv;
      3'd1:    r = av - bv;
      3'd2:    r = av * bv;
      3'd3:    r = (av >  bv) ? 1 : 0;
      3'd4:    r = (av <  bv) ? 1 : 0;
      3'd5:    r = (av == bv) ? 1 : 0;
      3'd6:    r = (av >= bv) ? 1 : 0;
      default: r = (av <= bv) ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; io[k] = '0; ia[k] = '0; ib[k] = '0; ordy[k] = 1'b0;
    end
  endtask

  // One-cycle reset; checks in_ready low during it and cleared outputs after.
  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    check("rst_in_ready_low", ir[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready_high", ir[0], 1'b1);
    check("rst_out_valid", ov[0], 1'b0);
    check("rst_c", oc[0], 8'h00);
    check("rst_c_opc", oo[0], 3'd0);
    check("rst_count", cnt[0], 8'd0);
    @(posedge clk); #1;
  endtask

  // Push one op through instance s with out_ready high; return its result.
  task automatic run_op(input int s, input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y, output logic [7:0] rc, output logic [2:0] ro);
    int n;
    iv[s] = 1'b1; io[s] = o; ia[s] = x; ib[s] = y; ordy[s] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir[s] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("op_accept", ir[s], 1'b1);
    @(posedge clk); #1;
    iv[s] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov[s] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("op_out_valid", ov[s], 1'b1);
    rc = oc[s];
    ro = oo[s];
    @(posedge clk); #1;
  endtask

  typedef struct {
    int         s;
    logic [2:0] o;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] e;
  } vec_t;

  typedef struct {
    logic [7:0] c;
    logic [2:0] o;
  } res_t;

  vec_t tbl [17];

  initial begin
    logic [7:0] rc;
    logic [2:0] ro;
    logic [2:0] bp_o [5];
    logic [3:0] bp_x [5];
    logic [3:0] bp_y [5];
    logic [7:0] bp_e [5];
    int next;
    int got;
    int cyc;
    int ghosts;
    int mcount;
    int n;
    res_t q[$];
    res_t r;

    tbl[0]  = '{0, 3'd1, 4'd3,  4'd5,  8'hFE};
    tbl[1]  = '{0, 3'd2, 4'd15, 4'd15, 8'hE1};
    tbl[2]  = '{0, 3'd3, 4'd9,  4'd2,  8'h01};
    tbl[3]  = '{0, 3'd5, 4'd7,  4'd7,  8'h01};
    tbl[4]  = '{0, 3'd0, 4'd15, 4'd15, 8'h1E};
    tbl[5]  = '{0, 3'd4, 4'd2,  4'd9,  8'h01};
    tbl[6]  = '{0, 3'd6, 4'd3,  4'd3,  8'h01};
    tbl[7]  = '{0, 3'd7, 4'd4,  4'd3,  8'h00};
    tbl[8]  = '{0, 3'd1, 4'd0,  4'd1,  8'hFF};
    tbl[9]  = '{1, 3'd3, 4'hF,  4'd1,  8'h00};
    tbl[10] = '{1, 3'd2, 4'hE,  4'd3,  8'hFA};
    tbl[11] = '{1, 3'd4, 4'hF,  4'd1,  8'h01};
    tbl[12] = '{1, 3'd0, 4'h8,  4'h8,  8'hF0};
    tbl[13] = '{1, 3'd1, 4'h7,  4'h8,  8'h0F};
    tbl[14] = '{1, 3'd2, 4'h8,  4'h8,  8'h40};
    tbl[15] = '{1, 3'd6, 4'h8,  4'h7,  8'h00};
    tbl[16] = '{1, 3'd7, 4'h8,  4'h7,  8'h01};

    rst = 1'b1;
    idle_all();
    @(posedge clk); #1;
    do_reset();

    // Latency: accept at edge N, result visible after edge N+1.
    iv[0] = 1'b1; io[0] = 3'd0; ia[0] = 4'd15; ib[0] = 4'd15; ordy[0] = 1'b1;
    @(negedge clk);
    check("lat_accept", ir[0], 1'b1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    check("lat_not_yet", ov[0], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_out_valid", ov[0], 1'b1);
    check("lat_c", oc[0], 8'h1E);
    check("lat_c_opc", oo[0], 3'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_count", cnt[0], 8'd1);
    check("lat_drained", ov[0], 1'b0);
    @(posedge clk); #1;

    // Table of per-opcode vectors.
    for (int i = 0; i < 17; i++) begin
      run_op(tbl[i].s, tbl[i].o, tbl[i].x, tbl[i].y, rc, ro);
      $display("vec %0d dut%0d opc=%0d a=%0h b=%0h c=%02h", i, tbl[i].s, tbl[i].o, tbl[i].x, tbl[i].y, rc);
      check("tbl_c", rc, tbl[i].e);
      check("tbl_c_opc", ro, tbl[i].o);
    end

    // Backpressure: consumer stalls 4 cycles while 5 ops are offered.
    do_reset();
    bp_o[0] = 3'd0; bp_x[0] = 4'd1; bp_y[0] = 4'd2;
    bp_o[1] = 3'd1; bp_x[1] = 4'd9; bp_y[1] = 4'd3;
    bp_o[2] = 3'd2; bp_x[2] = 4'd7; bp_y[2] = 4'd6;
    bp_o[3] = 3'd3; bp_x[3] = 4'd5; bp_y[3] = 4'd4;
    bp_o[4] = 3'd4; bp_x[4] = 4'd1; bp_y[4] = 4'd8;
    for (int k = 0; k < 5; k++) bp_e[k] = model(1'b0, bp_o[k], bp_x[k], bp_y[k]);
    next = 0; got = 0; cyc = 0;
    while (got < 5 && cyc < 40) begin
      ordy[0] = (cyc >= 4);
      iv[0] = (next < 5);
      if (next < 5) begin
        io[0] = bp_o[next]; ia[0] = bp_x[next]; ib[0] = bp_y[next];
      end
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        check("bp_in_ready_low", ir[0], 1'b0);
        check("bp_out_valid", ov[0], 1'b1);
        check("bp_c_stable", oc[0], bp_e[0]);
      end
      if (cyc == 3) check("bp_accepts", next, 2);
      if (iv[0] && ir[0]) next++;
      if (ov[0] && ordy[0]) begin
        $display("bp out %0d c=%02h opc=%0d", got, oc[0], oo[0]);
        check("bp_c", oc[0], bp_e[got]);
        check("bp_c_opc", oo[0], bp_o[got]);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv[0] = 1'b0;
    check("bp_all_out", got, 5);
    @(negedge clk);
    check("bp_count", cnt[0], 8'd5);
    @(posedge clk); #1;

    // Reset with both stages full: in-flight ops must vanish.
    do_reset();
    run_op(0, 3'd0, 4'd1, 4'd1, rc, ro);
    ordy[0] = 1'b0;
    iv[0] = 1'b1; io[0] = 3'd2; ia[0] = 4'd3; ib[0] = 4'd3;
    @(posedge clk); #1;
    iv[0] = 1'b1; io[0] = 3'd0; ia[0] = 4'd4; ib[0] = 4'd4;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    check("mid_full_valid", ov[0], 1'b1);
    check("mid_full_ready", ir[0], 1'b0);
    check("mid_count_before", cnt[0], 8'd1);
    rst = 1'b1; iv[0] = 1'b1; io[0] = 3'd1; ia[0] = 4'd2; ib[0] = 4'd1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    check("mid_out_valid", ov[0], 1'b0);
    check("mid_count", cnt[0], 8'd0);
    check("mid_c", oc[0], 8'h00);
    ghosts = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ov[0]) ghosts++;
    end
    check("mid_no_ghosts", ghosts, 0);
    check("mid_count_after", cnt[0], 8'd0);
    @(posedge clk); #1;

    // Counter wrap on the 2-bit instance.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_op(2, 3'd0, 4'(k), 4'd1, rc, ro);
      @(negedge clk);
      $display("wrap handoff %0d op_count=%0d", k + 1, cnt[2]);
      check("wrap_count", cnt[2], 32'((k + 1) % 4));
      @(posedge clk); #1;
    end

    // Randomized traffic on the unsigned and signed instances.
    for (int s = 0; s < 2; s++) begin
      do_reset();
      q.delete();
      mcount = 0;
      for (int t = 0; t < 300; t++) begin
        iv[s] = ($urandom % 4) != 0;
        io[s] = 3'($urandom);
        ia[s] = 4'($urandom);
        ib[s] = 4'($urandom);
        ordy[s] = ($urandom % 3) != 0;
        @(negedge clk);
        if (ov[s] && ordy[s]) begin
          if (q.size() == 0) begin
            check("rnd_spurious", 1, 0);
          end else begin
            r = q.pop_front();
            $display("rnd dut%0d c=%02h opc=%0d", s, oc[s], oo[s]);
            check("rnd_c", oc[s], r.c);
            check("rnd_c_opc", oo[s], r.o);
          end
          mcount++;
        end
        if (iv[s] && ir[s]) q.push_back('{model(s == 1, io[s], ia[s], ib[s]), io[s]});
        @(posedge clk); #1;
      end
      iv[s] = 1'b0;
      ordy[s] = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 20) begin
        @(negedge clk);
        if (ov[s]) begin
          r = q.pop_front();
          check("rnd_drain_c", oc[s], r.c);
          check("rnd_drain_c_opc", oo[s], r.o);
          mcount++;
        end
        @(posedge clk); #1;
        n++;
      end
      check("rnd_drained", q.size(), 0);
      @(negedge clk);
      check("rnd_count", cnt[s], 32'(mcount % 256));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
